program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Sequences the CPU's programming mode: accepts a byte stream from the ui_in pins over a
//  valid/ready handshake, writes it to RAM addresses 0..DEPTH-1 and then releases the CPU.
//  Drives the control block's `programming` input and the RAM write port.
//  Holds the CPU in reset while a load is in progress or after a failed load.
// PARAMETERS
//  ADDR_W       4    RAM address width
//  DATA_W       8    RAM word width (= ui_in width)
//  DEPTH        16   words per program image; must be <= 2**ADDR_W
//  TIMEOUT      255  max idle clk cycles between accepted bytes while loading; must be >= 1
// PORTS
//  clk          in   1       system clock; all state changes on the posedge
//  resetn       in   1       asynchronous, active-low reset
//  start        in   1       level-sampled; request a (re)load; ignored in LOAD and CHECK
//  ui_data      in   DATA_W  incoming program byte
//  ui_valid     in   1       ui_data is valid
//  ui_ready     out  1       loader can accept a byte; byte taken when ui_valid & ui_ready
//  prog_addr    out  ADDR_W  RAM write address
//  prog_data    out  DATA_W  RAM write data
//  prog_we      out  1       1-cycle RAM write strobe
//  programming  out  1       to control block; high in LOAD and CHECK
//  cpu_resetn   out  1       CPU reset, active-low; high only in RUN
//  done         out  1       image loaded and accepted; high in RUN
//  error        out  1       load failed (timeout or checksum); high in ERROR
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (incl. cpu_resetn=0); addr, idle and checksum counters 0.
//  FSM: IDLE -start-> LOAD; LOAD -last byte-> RUN (or CHECK when the macro is defined);
//   LOAD -timeout-> ERROR; CHECK -checksum byte-> RUN | ERROR; RUN,ERROR -start-> LOAD.
//  Entry to LOAD clears addr, idle count and checksum; ui_ready=1 from the next cycle.
//  Accept at edge N: prog_addr=addr, prog_data=ui_data, prog_we=1 for cycle N+1 (latency 1).
//   addr increments and the idle counter clears on each accept.
//  Accept with addr==DEPTH-1: ui_ready drops in the next cycle; the write still issues.
//   programming stays high through that write cycle, then the FSM leaves LOAD.
//  No address wrap: exactly DEPTH bytes per image. Extra bytes are not accepted.
//  Idle counter increments on each LOAD cycle without an accept.
//   Reaching TIMEOUT -> ERROR; ui_ready and programming drop next cycle.
//   An accept in the same cycle as reaching TIMEOUT wins; the counter clears.
//  RUN: cpu_resetn=1, done=1, programming=0.
//   start in RUN -> LOAD; cpu_resetn falls in the same edge's cycle.
//  ERROR: error=1, cpu_resetn=0; sticky until start or resetn.
//  resetn mid-load: immediate return to reset values; partially written RAM is not cleared.
//  prog_addr/prog_data hold their last value when prog_we=0.
// CONFIGURATION
//  PROG_LOADER_CHECKSUM_EN defined:
//   after DEPTH data bytes, FSM enters CHECK, ui_ready=1, and one extra byte is accepted.
//   That byte is never written to RAM (prog_we=0).
//   (sum of data bytes + checksum byte) mod 2**DATA_W == 0 -> RUN, else -> ERROR.
//   Timeout rules also apply in CHECK.
//  Not defined: no CHECK state; the final write cycle goes directly to RUN;
//   no checksum logic synthesised.
// STRUCTURE
//  Shared package sap_pkg: FSM state encoding (IDLE, LOAD, CHECK, RUN, ERROR),
//   default ADDR_W/DATA_W/DEPTH constants shared with control_block and RAM.
//  One sub-module: loader_timeout_ctr (clear, enable, TIMEOUT param -> expired pulse).
// TESTING
//  1 Reset then start; 16 bytes 0x10..0x1F with ui_valid held high -> 16 prog_we pulses.
//    Addr 0..15 / data 0x10..0x1F; done=1, cpu_resetn=1 two cycles after the last accept.
//  2 Gaps of 3 cycles between bytes, TIMEOUT=255 -> load completes.
//    Gap of 255 after byte 5 -> error=1, programming=0, no further prog_we.
//  3 Assert resetn=0 after byte 7 -> all outputs 0 asynchronously.
//    After release, start -> reload begins at addr 0.
//  4 In RUN, pulse start -> cpu_resetn=0, done=0, programming=1; a new 16-byte load succeeds.
//  5 With PROG_LOADER_CHECKSUM_EN: 16 bytes of 0x01, then checksum 0xF0 -> RUN.
//    Checksum 0xF1 instead -> ERROR; 16 writes only.
//  6 ui_valid held high after the last byte -> ui_ready=0, no 17th write, no address wrap.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: loader FSM state encoding and default bus/memory sizes
// used by program_loader, the control block and the program RAM.
package sap_pkg;

  localparam int SAP_ADDR_W  = 4;
  localparam int SAP_DATA_W  = 8;
  localparam int SAP_DEPTH   = 16;
  localparam int SAP_TIMEOUT = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } loader_state_t;

endpackage

// File: rtl/loader_timeout_ctr.sv
// Idle-cycle watchdog for the program loader: counts enabled cycles since the last clear
// and pulses o_expired on the cycle whose increment reaches TIMEOUT.
module loader_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  assign o_expired = i_enable && (r_count == LAST_CNT);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_count <= '0;
    end else if (i_clear || o_expired) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Programming-mode sequencer: streams DEPTH bytes from ui_in into program RAM, then
// releases the CPU. Define PROG_LOADER_CHECKSUM_EN to require a trailing checksum byte.
module program_loader
  import sap_pkg::*;
#(
  parameter int ADDR_W  = SAP_ADDR_W,
  parameter int DATA_W  = SAP_DATA_W,
  parameter int DEPTH   = SAP_DEPTH,
  parameter int TIMEOUT = SAP_TIMEOUT
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_ui_data,
  input  logic              i_ui_valid,
  output logic              o_ui_ready,
  output logic [ADDR_W-1:0] o_prog_addr,
  output logic [DATA_W-1:0] o_prog_data,
  output logic              o_prog_we,
  output logic              o_programming,
  output logic              o_cpu_resetn,
  output logic              o_done,
  output logic              o_error
);

  // One extra count bit so "all DEPTH words taken" is distinct from address DEPTH-1.
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  loader_state_t r_state, w_nextState;

  logic [ADDR_W:0]   r_count;
  logic [ADDR_W-1:0] r_progAddr;
  logic [DATA_W-1:0] r_progData;
  logic              r_progWe;

  logic w_full, w_ready, w_accept, w_write, w_startLoad, w_expired;

  assign w_full      = (r_count == FULL_CNT);
  assign w_ready     = ((r_state == ST_LOAD) && !w_full) || (r_state == ST_CHECK);
  assign w_accept    = w_ready && i_ui_valid;
  assign w_write     = w_accept && (r_state == ST_LOAD);
  assign w_startLoad = i_start && (r_state inside {ST_IDLE, ST_RUN, ST_ERROR});

  loader_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .i_clk     (i_clk),
    .i_resetn  (i_resetn),
    .i_clear   (!w_ready || w_accept),
    .i_enable  (w_ready && !w_accept),
    .o_expired (w_expired)
  );

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic [DATA_W-1:0] w_sumTotal;
  logic              w_sumOk;

  assign w_sumTotal = r_sum + i_ui_data;
  assign w_sumOk    = (w_sumTotal == '0);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_sum <= '0;
    end else if (w_startLoad) begin
      r_sum <= '0;
    end else if (w_write) begin
      r_sum <= w_sumTotal;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (i_start) w_nextState = ST_LOAD;
      end
      ST_LOAD: begin
        // Leave only after the final write cycle has been issued.
        if (w_full) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          w_nextState = ST_CHECK;
`else
          w_nextState = ST_RUN;
`endif
        end else if (w_expired) begin
          w_nextState = ST_ERROR;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (w_accept)       w_nextState = w_sumOk ? ST_RUN : ST_ERROR;
        else if (w_expired) w_nextState = ST_ERROR;
      end
`endif
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_count    <= '0;
      r_progAddr <= '0;
      r_progData <= '0;
      r_progWe   <= 1'b0;
    end else begin
      r_progWe <= w_write;
      if (w_startLoad) begin
        r_count <= '0;
      end else if (w_write) begin
        r_count    <= r_count + (ADDR_W + 1)'(1);
        r_progAddr <= r_count[ADDR_W-1:0];
        r_progData <= i_ui_data;
      end
    end
  end

  assign o_ui_ready    = w_ready;
  assign o_prog_addr   = r_progAddr;
  assign o_prog_data   = r_progData;
  assign o_prog_we     = r_progWe;
  assign o_programming = (r_state == ST_LOAD) || (r_state == ST_CHECK);
  assign o_cpu_resetn  = (r_state == ST_RUN);
  assign o_done        = (r_state == ST_RUN);
  assign o_error       = (r_state == ST_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed load scenarios plus random traffic,
// compared every cycle against a transaction-level model of the loader.
module tb_program_loader;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 255;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam int P_IDLE = 0, P_LOAD = 1, P_CHECK = 2, P_RUN = 3, P_FAIL = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       start = 1'b0;
  logic [7:0] uiData = '0;
  logic       uiValid = 1'b0;
  logic       uiReady, progWe, programming, cpuResetn, done, error;
  logic [3:0] progAddr;
  logic [7:0] progData;

  int checks = 0;
  int errors = 0;

  int         mPhase, mTaken, mIdle;
  logic [7:0] mSum, mData;
  logic [3:0] mAddr;
  logic       mWe;
  logic [7:0] obsMem [DEPTH];
  int         obsWrites;

  program_loader dut (
    .i_clk         (clk),
    .i_resetn      (resetn),
    .i_start       (start),
    .i_ui_data     (uiData),
    .i_ui_valid    (uiValid),
    .o_ui_ready    (uiReady),
    .o_prog_addr   (progAddr),
    .o_prog_data   (progData),
    .o_prog_we     (progWe),
    .o_programming (programming),
    .o_cpu_resetn  (cpuResetn),
    .o_done        (done),
    .o_error       (error)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit mReady();
    return ((mPhase == P_LOAD) && (mTaken < DEPTH)) || (mPhase == P_CHECK);
  endfunction

  task automatic modelReset();
    mPhase = P_IDLE; mTaken = 0; mIdle = 0; mSum = '0;
    mWe = 1'b0; mAddr = '0; mData = '0;
  endtask

  // One clock edge of the loader's specified behaviour, using pre-edge state.
  task automatic modelStep(input bit st, input bit v, input logic [7:0] d);
    bit acc;
    acc = mReady() && v;
    mWe = acc && (mPhase == P_LOAD);
    if (mWe) begin
      mAddr = mTaken[3:0];
      mData = d;
    end
    case (mPhase)
      P_IDLE, P_RUN, P_FAIL: begin
        if (st) begin
          mPhase = P_LOAD; mTaken = 0; mIdle = 0; mSum = '0;
        end
      end
      P_LOAD: begin
        if (mTaken == DEPTH) begin
          mPhase = CHK ? P_CHECK : P_RUN;
          mIdle = 0;
        end else if (acc) begin
          mTaken++; mSum = mSum + d; mIdle = 0;
        end else begin
          mIdle++;
          if (mIdle == TIMEOUT) mPhase = P_FAIL;
        end
      end
      P_CHECK: begin
        if (acc) begin
          mPhase = (8'(mSum + d) == 8'h00) ? P_RUN : P_FAIL;
        end else begin
          mIdle++;
          if (mIdle == TIMEOUT) mPhase = P_FAIL;
        end
      end
      default: mPhase = P_IDLE;
    endcase
  endtask

  task automatic checkOutput();
    checkVal("ui_ready",    uiReady,     mReady());
    checkVal("programming", programming, (mPhase == P_LOAD) || (mPhase == P_CHECK));
    checkVal("cpu_resetn",  cpuResetn,   mPhase == P_RUN);
    checkVal("done",        done,        mPhase == P_RUN);
    checkVal("error",       error,       mPhase == P_FAIL);
    checkVal("prog_we",     progWe,      mWe);
    checkVal("prog_addr",   progAddr,    mAddr);
    checkVal("prog_data",   progData,    mData);
    if (progWe === 1'b1) begin
      obsMem[progAddr] = progData;
      obsWrites++;
    end
  endtask

  task automatic applyStimulus(input bit st, input bit v, input logic [7:0] d);
    start = st; uiValid = v; uiData = d;
    @(posedge clk);
    modelStep(st, v, d);
    #1;
    checkOutput();
  endtask

  task automatic idleTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic doReset();
    resetn = 1'b0; start = 1'b0; uiValid = 1'b0;
    #2;
    modelReset();
    checkOutput();
    @(posedge clk);
    #1;
    checkOutput();
    resetn = 1'b1;
  endtask

  // Supplies the trailing checksum byte when the checksum build is under test.
  task automatic finishImage();
    if (CHK) applyStimulus(1'b0, 1'b1, 8'(-mSum));
  endtask

  initial begin
    $display("[TB] program_loader bench start (checksum build = %0d)", CHK);
    obsWrites = 0;
    #2;
    doReset();
    checkVal("rst_cpu_resetn", cpuResetn, 1'b0);

    // Back-to-back image 0x10..0x1F
    applyStimulus(1'b1, 1'b0, 8'h00);
    obsWrites = 0;
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 8'(8'h10 + i));
    applyStimulus(1'b0, 1'b0, 8'h00);
    finishImage();
    checkVal("t1_writes", obsWrites, DEPTH);
    checkVal("t1_done", done, 1'b1);
    checkVal("t1_cpu_resetn", cpuResetn, 1'b1);
    for (int i = 0; i < DEPTH; i++) checkVal("t1_mem", obsMem[i], 32'(8'h10 + i));

    // Valid held high past the last byte: no 17th write, no wrap
    applyStimulus(1'b1, 1'b0, 8'h00);
    obsWrites = 0;
    for (int i = 0; i < DEPTH + 4; i++) applyStimulus(1'b0, 1'b1, 8'($urandom));
    checkVal("t6_writes", obsWrites, DEPTH);
    idleTicks(2);
    finishImage();

    // 3-cycle gaps complete normally
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 8'($urandom));
      idleTicks(3);
    end
    finishImage();
    checkVal("t2_done", done, 1'b1);

    // Long gap after byte 5 times out
    applyStimulus(1'b1, 1'b0, 8'h00);
    obsWrites = 0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'($urandom));
    idleTicks(TIMEOUT + 5);
    checkVal("t2_error", error, 1'b1);
    checkVal("t2_programming", programming, 1'b0);
    checkVal("t2_writes", obsWrites, 5);

    // Reset in the middle of a load, then reload from address 0
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 8'($urandom));
    doReset();
    checkVal("t3_programming", programming, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'hA5);
    checkVal("t3_addr0", progAddr, 4'd0);
    checkVal("t3_we", progWe, 1'b1);
    for (int i = 1; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 8'($urandom));
    idleTicks(1);
    finishImage();
    checkVal("t3_done", done, 1'b1);

    // Restart from RUN
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkVal("t4_cpu_resetn", cpuResetn, 1'b0);
    checkVal("t4_done", done, 1'b0);
    checkVal("t4_programming", programming, 1'b1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 8'($urandom));
    idleTicks(1);
    finishImage();
    checkVal("t4_reload_done", done, 1'b1);

`ifdef PROG_LOADER_CHECKSUM_EN
    applyStimulus(1'b1, 1'b0, 8'h00);
    obsWrites = 0;
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 8'h01);
    idleTicks(1);
    applyStimulus(1'b0, 1'b1, 8'hF0);
    checkVal("t5_good_done", done, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 8'h01);
    idleTicks(1);
    applyStimulus(1'b0, 1'b1, 8'hF1);
    checkVal("t5_bad_error", error, 1'b1);
    checkVal("t5_writes", obsWrites, 2 * DEPTH);
`endif

    // Random traffic, including starts that must be ignored mid-load
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
